// File: rtl/io_uart_tx_pkg.sv
// Shared constants for the UART transmitter: FSM state encodings and default timing.
package io_uart_tx_pkg;

    localparam logic [1:0] UART_IDLE  = 2'd0;
    localparam logic [1:0] UART_START = 2'd1;
    localparam logic [1:0] UART_DATA  = 2'd2;
    localparam logic [1:0] UART_STOP  = 2'd3;

    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam int unsigned UART_FIFO_DEPTH   = 4;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module io_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// 8N1 UART transmitter fed by the output-port write strobe through a small FIFO.
module io_uart_tx
    import io_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic              tx,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned BW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW    = $clog2(DATA_W);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_W - 1);

    logic [1:0]                  state_q, state_d;
    logic [BW-1:0]               baud_q, baud_d;
    logic [IW-1:0]               bit_q, bit_d;
    logic [DATA_W-1:0]           shift_q, shift_d;
    logic                        tx_q, tx_d;
    logic                        overflow_q, overflow_d;
    logic                        pop;
    logic                        baud_last;
    logic [DATA_W-1:0]           fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (we),
        .pop   (pop),
        .din   (din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    // tx_d is the line level for the state being entered, so tx is a clean register output.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_last ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            UART_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = UART_START;
                    tx_d    = 1'b0;
                end
            end
            UART_START: begin
                if (baud_last) begin
                    state_d = UART_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            UART_DATA: begin
                if (baud_last) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            default: begin
                if (baud_last) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = UART_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = UART_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    // A write is dropped only when the FIFO is full and nothing leaves it this cycle.
    assign overflow_d = overflow_q | (we & full & ~pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UART_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != UART_IDLE);
    assign overflow = overflow_q;

endmodule
